// File: rtl/perceptron_core_if.sv
// Handshake, weight-port and result bundle between the pattern source/display
// and perceptron_core. The master drives requests; the core (slave) answers.
interface perceptron_core_if #(
    parameter int N_IN  = 20,
    parameter int N_OUT = 8,
    parameter int W_W   = 8
);
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int IW = $clog2(N_IN + 1);
    localparam int EW = $clog2(N_OUT + 1);

    logic                  start;
    logic                  train;
    logic [N_IN-1:0]       pattern;
    logic [OW-1:0]         label;
    logic                  wr_en;
    logic [OW-1:0]         wr_neuron;
    logic [IW-1:0]         wr_index;
    logic signed [W_W-1:0] wr_data;
    logic signed [W_W-1:0] rd_data;
    logic                  busy;
    logic                  done;
    logic [N_OUT-1:0]      fire;
    logic [OW-1:0]         winner;
    logic [EW-1:0]         err_cnt;

    modport master (
        output start, train, pattern, label, wr_en, wr_neuron, wr_index, wr_data,
        input  rd_data, busy, done, fire, winner, err_cnt
    );

    modport slave (
        input  start, train, pattern, label, wr_en, wr_neuron, wr_index, wr_data,
        output rd_data, busy, done, fire, winner, err_cnt
    );
endinterface

// File: rtl/perceptron_core.sv
// Sequential single-adder perceptron: scores a binary pattern against N_OUT
// weight rows, reports fire bits and argmax, and optionally applies the learning rule.
module perceptron_core #(
    parameter int N_IN  = 20,
    parameter int N_OUT = 8,
    parameter int W_W   = 8
) (
    input logic              clk,
    input logic              rst,
    perceptron_core_if.slave bus
);
    localparam int ACC_W = W_W + $clog2(N_IN + 2);
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int IW    = $clog2(N_IN + 1);
    localparam int EW    = $clog2(N_OUT + 1);

    localparam logic [IW-1:0]           I_LAST   = IW'(N_IN - 1);
    localparam logic [IW-1:0]           I_BIAS   = IW'(N_IN);
    localparam logic [OW-1:0]           O_LAST   = OW'(N_OUT - 1);
    localparam logic [OW:0]             N_OUT_L  = (OW + 1)'(N_OUT);
    localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;
    localparam logic signed [W_W:0]     SAT_MAX  = {2'b00, {(W_W - 1){1'b1}}};
    localparam logic signed [W_W:0]     SAT_MIN  = {2'b11, {(W_W - 1){1'b0}}};
    localparam logic signed [W_W:0]     DELTA_UP = (W_W + 1)'(1);
    localparam logic signed [W_W:0]     DELTA_DN = '1;

    typedef enum logic [2:0] {IDLE, ACC, DECIDE, UPDATE, DONE} state_t;

    state_t                  state_q;
    logic [OW-1:0]           o_q;
    logic [IW-1:0]           i_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] best_q;
    logic [N_IN-1:0]         pattern_q;
    logic [OW-1:0]           label_q;
    logic                    train_q;
    logic                    tgt_q;
    logic                    busy_q;
    logic                    done_q;
    logic [N_OUT-1:0]        fire_q;
    logic [OW-1:0]           winner_q;
    logic [EW-1:0]           err_cnt_q;
    // Column N_IN of each row holds that neuron's bias.
    logic signed [W_W-1:0]   w_q [N_OUT][N_IN+1];

    logic signed [W_W-1:0]   w_cur;
    logic signed [W_W-1:0]   w_bias;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_add;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [W_W:0]     delta;
    logic signed [W_W:0]     upd_sum;
    logic signed [W_W-1:0]   upd_sat;
    logic                    pix;
    logic                    inc;
    logic                    tgt_now;
    logic                    fire_now;
    logic                    accept;
    logic                    wr_ok;
    logic                    rd_ok;

    always_comb begin
        w_cur    = w_q[o_q][i_q];
        w_bias   = w_q[o_q][N_IN];
        pix      = pattern_q[i_q];
        acc_base = (i_q == '0) ? {{(ACC_W - W_W){w_bias[W_W-1]}}, w_bias} : acc_q;
        acc_add  = pix ? {{(ACC_W - W_W){w_cur[W_W-1]}}, w_cur} : ACC_ZERO;
        acc_sum  = acc_base + acc_add;
        tgt_now  = (label_q == o_q);
        fire_now = (acc_q > ACC_ZERO);

        // Bias always moves by one; weights only where the pixel was lit.
        inc      = (i_q == I_BIAS) || pix;
        delta    = inc ? (tgt_q ? DELTA_UP : DELTA_DN) : '0;
        upd_sum  = {w_cur[W_W-1], w_cur} + delta;
        if (upd_sum > SAT_MAX) begin
            upd_sat = SAT_MAX[W_W-1:0];
        end else if (upd_sum < SAT_MIN) begin
            upd_sat = SAT_MIN[W_W-1:0];
        end else begin
            upd_sat = upd_sum[W_W-1:0];
        end

        accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
        rd_ok  = (bus.wr_index <= I_BIAS) && ({1'b0, bus.wr_neuron} < N_OUT_L);
        wr_ok  = bus.wr_en && (state_q == IDLE) && rd_ok;
    end

    assign bus.rd_data = rd_ok ? w_q[bus.wr_neuron][bus.wr_index] : '0;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.fire    = fire_q;
    assign bus.winner  = winner_q;
    assign bus.err_cnt = err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            o_q       <= '0;
            i_q       <= '0;
            acc_q     <= '0;
            best_q    <= '0;
            pattern_q <= '0;
            label_q   <= '0;
            train_q   <= 1'b0;
            tgt_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fire_q    <= '0;
            winner_q  <= '0;
            err_cnt_q <= '0;
            for (int n = 0; n < N_OUT; n++) begin
                for (int i = 0; i <= N_IN; i++) begin
                    w_q[n][i] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            if (wr_ok) begin
                w_q[bus.wr_neuron][bus.wr_index] <= bus.wr_data;
            end
            if (accept) begin
                pattern_q <= bus.pattern;
                label_q   <= bus.label;
                train_q   <= bus.train;
                o_q       <= '0;
                i_q       <= '0;
                err_cnt_q <= '0;
                busy_q    <= 1'b1;
                state_q   <= ACC;
            end else begin
                case (state_q)
                    ACC: begin
                        acc_q <= acc_sum;
                        if (i_q == I_LAST) begin
                            state_q <= DECIDE;
                        end else begin
                            i_q <= i_q + IW'(1);
                        end
                    end
                    DECIDE: begin
                        fire_q[o_q] <= fire_now;
                        // Strict compare keeps the lower index on ties.
                        if ((o_q == '0) || (acc_q > best_q)) begin
                            best_q   <= acc_q;
                            winner_q <= o_q;
                        end
                        i_q <= '0;
                        if (train_q && (fire_now != tgt_now)) begin
                            tgt_q     <= tgt_now;
                            err_cnt_q <= err_cnt_q + EW'(1);
                            state_q   <= UPDATE;
                        end else if (o_q == O_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            o_q     <= o_q + OW'(1);
                            state_q <= ACC;
                        end
                    end
                    UPDATE: begin
                        w_q[o_q][i_q] <= upd_sat;
                        if (i_q == I_BIAS) begin
                            i_q <= '0;
                            if (o_q == O_LAST) begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                o_q     <= o_q + OW'(1);
                                state_q <= ACC;
                            end
                        end else begin
                            i_q <= i_q + IW'(1);
                        end
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_perceptron_core.sv
// Directed bench for perceptron_core: a behavioural weight model predicts each
// run's results, which are queued at start and compared when done pulses.
module tb_perceptron_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   mw [8][21];

    typedef struct {
        logic [7:0] fire;
        logic [2:0] winner;
        logic [3:0] err;
        int         cycles;
    } exp_t;
    exp_t sbq[$];

    perceptron_core_if #(.N_IN(20), .N_OUT(8), .W_W(8)) bus ();
    perceptron_core #(.N_IN(20), .N_OUT(8), .W_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic void model_clear();
        for (int n = 0; n < 8; n++)
            for (int i = 0; i < 21; i++) mw[n][i] = 0;
    endfunction

    function automatic void model_run(input bit tr, input logic [19:0] pat, input int lab);
        exp_t e;
        int best;
        int score;
        bit f;
        bit t;
        e.fire = '0; e.winner = '0; e.err = '0; best = 0;
        for (int o = 0; o < 8; o++) begin
            score = mw[o][20];
            for (int i = 0; i < 20; i++) if (pat[i]) score += mw[o][i];
            f = (score > 0);
            e.fire[o] = f;
            if (o == 0 || score > best) begin best = score; e.winner = 3'(o); end
            t = (o == lab);
            if (tr && f != t) begin
                e.err = e.err + 4'd1;
                for (int i = 0; i < 21; i++)
                    if (i == 20 || pat[i]) mw[o][i] = sat8(mw[o][i] + (t ? 1 : -1));
            end
        end
        e.cycles = 8 * 21 + 1 + int'(e.err) * 21;
        sbq.push_back(e);
    endfunction

    task automatic wr(input int n, input int i, input int d);
        logic [31:0] dv;
        dv = d;
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_neuron = 3'(n); bus.wr_index = 5'(i); bus.wr_data = dv[7:0];
        @(negedge clk);
        bus.wr_en = 1'b0;
        mw[n][i] = d;
    endtask

    task automatic check_array(input string tag);
        logic [31:0] ev;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 21; i++) begin
                bus.wr_neuron = 3'(n); bus.wr_index = 5'(i);
                #1;
                ev = mw[n][i];
                chk($sformatf("%s_w[%0d][%0d]", tag, n, i), {24'b0, bus.rd_data}, {24'b0, ev[7:0]});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_clear();
    endtask

    // disturb>0: pulse start+wr_en at that cycle; co_wr: write alongside start.
    task automatic do_run(input string tag, input bit tr, input logic [19:0] pat, input int lab,
                          input int disturb, input bit co_wr, input int cn, input int ci, input int cd);
        exp_t e;
        int cyc;
        int extra;
        logic [31:0] dv;
        @(negedge clk);
        bus.start = 1'b1; bus.train = tr; bus.pattern = pat; bus.label = 3'(lab);
        if (co_wr) begin
            dv = cd;
            bus.wr_en = 1'b1; bus.wr_neuron = 3'(cn); bus.wr_index = 5'(ci); bus.wr_data = dv[7:0];
            mw[cn][ci] = cd;
        end
        model_run(tr, pat, lab);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.wr_en = 1'b0;
        chk({tag, "_busy_edge0"}, {31'b0, bus.busy}, 32'd1);
        cyc = 1;
        while (!bus.done && cyc < 400) begin
            if (cyc == disturb) begin
                @(negedge clk);
                bus.start = 1'b1; bus.train = 1'b1; bus.wr_en = 1'b1;
                bus.wr_neuron = 3'd4; bus.wr_index = 5'd0; bus.wr_data = 8'd55;
                @(posedge clk); #1;
                bus.start = 1'b0; bus.wr_en = 1'b0; bus.train = tr;
            end else begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        e = sbq.pop_front();
        chk({tag, "_done_seen"}, {31'b0, bus.done}, 32'd1);
        chk({tag, "_cycles"}, cyc, e.cycles);
        chk({tag, "_fire"}, {24'b0, bus.fire}, {24'b0, e.fire});
        chk({tag, "_winner"}, {29'b0, bus.winner}, {29'b0, e.winner});
        chk({tag, "_err_cnt"}, {28'b0, bus.err_cnt}, {28'b0, e.err});
        chk({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, "_done_after"}, {31'b0, bus.done}, 32'd0);
        if (disturb > 0) begin
            extra = 0;
            repeat (30) begin @(posedge clk); #1; if (bus.done) extra++; end
            chk({tag, "_single_done"}, extra, 0);
        end
    endtask

    initial begin
        int cyc;
        int seen;
        logic [19:0] p3;
        bus.start = 1'b0; bus.train = 1'b0; bus.pattern = '0; bus.label = '0;
        bus.wr_en = 1'b0; bus.wr_neuron = '0; bus.wr_index = '0; bus.wr_data = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_fire", {24'b0, bus.fire}, 32'd0);
        chk("rst_winner", {29'b0, bus.winner}, 32'd0);
        chk("rst_err_cnt", {28'b0, bus.err_cnt}, 32'd0);
        check_array("rst");

        do_run("zero_classify", 1'b0, 20'hFFFFF, 0, 0, 1'b0, 0, 0, 0);

        p3 = 20'b11111001100110011001;
        for (int i = 0; i < 20; i++) if (p3[i]) wr(3, i, 1);
        do_run("row3_classify", 1'b0, p3, 0, 0, 1'b0, 0, 0, 0);
        @(negedge clk); bus.wr_neuron = 3'd3; bus.wr_index = 5'd0; #1;
        chk("row3_readback_w30", {24'b0, bus.rd_data}, 32'h01);

        do_reset();
        for (int i = 0; i < 20; i += 2) begin wr(2, i, 3); wr(5, i, 3); end
        do_run("tie", 1'b0, 20'h55555, 0, 0, 1'b0, 0, 0, 0);

        do_run("start_with_write", 1'b0, 20'h00000, 0, 0, 1'b1, 6, 20, 5);

        do_reset();
        do_run("train1", 1'b1, 20'hF8888, 1, 0, 1'b0, 0, 0, 0);
        check_array("train1");
        do_run("train2", 1'b1, 20'hF8888, 1, 0, 1'b0, 0, 0, 0);

        do_run("ignore_midrun", 1'b0, 20'h0F0F0, 0, 30, 1'b0, 0, 0, 0);
        check_array("ignore_midrun");

        // Reset in cycle 50 of a run.
        @(negedge clk);
        bus.start = 1'b1; bus.train = 1'b1; bus.pattern = 20'hABCDE; bus.label = 3'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        repeat (49) begin @(posedge clk); #1; cyc++; end
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_done", {31'b0, bus.done}, 32'd0);
        model_clear();
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (200) begin @(posedge clk); #1; if (bus.done) seen++; end
        chk("midrst_no_done", seen, 0);
        check_array("midrst");

        do_reset();
        for (int i = 0; i < 10; i++) wr(0, i, 127);
        for (int i = 10; i < 21; i++) wr(0, i, -128);
        for (int r = 0; r < 20; r++) do_run($sformatf("sat_hi%0d", r), 1'b1, 20'hFFFFF, 0, 0, 1'b0, 0, 0, 0);
        check_array("sat_hi");

        do_reset();
        for (int i = 0; i < 10; i++) wr(0, i, -128);
        for (int i = 10; i < 21; i++) wr(0, i, 127);
        for (int r = 0; r < 5; r++) do_run($sformatf("sat_lo%0d", r), 1'b1, 20'hFFFFF, 1, 0, 1'b0, 0, 0, 0);
        check_array("sat_lo");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
